// File: rtl/game_controller.sv
// game_controller
// Frame-synchronous game sequencer that feeds sprite_drawer. It owns the
// invader block, ship and bullet positions, samples the player buttons,
// advances every object once per video frame, resolves bullet/invader hits
// and runs the IDLE/PLAY/WIN/LOSE state machine. Every output is a register
// that only changes on the clk edge sampling frame_tick=1, so sprites stay
// stable through active video.
//
// Ports
//   clk            in   system clock
//   reset          in   asynchronous, active-low reset
//   frame_tick     in   one-cycle pulse at start of vertical blanking
//   btn_left       in   level, debounced, synchronous to clk
//   btn_right      in   level, debounced, synchronous to clk
//   btn_fire       in   level, debounced; rising edge = fire request
//   invaders_array out  bit i = invader alive in column i
//   invaders_line  out  sprite row of the invader block
//   ship_x         out  ship column
//   bullet_x       out  bullet column
//   bullet_y       out  bullet row
//   bullet_flying  out  bullet visible/active
//   game_state     out  0=IDLE 1=PLAY 2=WIN 3=LOSE
//   score          out  invaders destroyed, saturating at 255
module game_controller #(
  parameter int              COLS       = 20,
  parameter int              SHIP_ROW   = 13,
  parameter int              START_LINE = 1,
  parameter int              SHIP_START = 9,
  parameter logic [COLS-1:0] INIT_ARRAY = 20'h0FFF0,
  parameter int              SHIP_DIV   = 4,
  parameter int              BULLET_DIV = 2,
  parameter int              INV_DIV    = 30
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            frame_tick,
  input  logic            btn_left,
  input  logic            btn_right,
  input  logic            btn_fire,
  output logic [COLS-1:0] invaders_array,
  output logic [4:0]      invaders_line,
  output logic [4:0]      ship_x,
  output logic [4:0]      bullet_x,
  output logic [3:0]      bullet_y,
  output logic            bullet_flying,
  output logic [1:0]      game_state,
  output logic [7:0]      score
);

  localparam int SHIP_CW   = (SHIP_DIV   > 1) ? $clog2(SHIP_DIV)   : 1;
  localparam int BULLET_CW = (BULLET_DIV > 1) ? $clog2(BULLET_DIV) : 1;
  localparam int INV_CW    = (INV_DIV    > 1) ? $clog2(INV_DIV)    : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_WIN  = 2'd2,
    ST_LOSE = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [COLS-1:0]       inv_array_q, inv_array_d;
  logic [4:0]            inv_line_q, inv_line_d;
  logic                  dir_right_q, dir_right_d;
  logic [4:0]            ship_x_q, ship_x_d;
  logic [4:0]            bullet_x_q, bullet_x_d;
  logic [3:0]            bullet_y_q, bullet_y_d;
  logic                  flying_q, flying_d;
  logic [7:0]            score_q, score_d;
  logic [SHIP_CW-1:0]    ship_cnt_q, ship_cnt_d;
  logic [BULLET_CW-1:0]  bullet_cnt_q, bullet_cnt_d;
  logic [INV_CW-1:0]     inv_cnt_q, inv_cnt_d;
  logic                  fire_pending_q, fire_pending_d;
  logic                  fire_prev_q, fire_prev_d;

  logic                  play_tick;
  logic                  start_game;
  logic                  restart_game;
  logic                  ship_wrap;
  logic                  bullet_wrap;
  logic                  inv_wrap;
  logic                  hit;
  logic [COLS-1:0]       post_hit_array;

  // All state lives here; reset loads the (re)initialisation values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      inv_array_q    <= INIT_ARRAY;
      inv_line_q     <= 5'(START_LINE);
      dir_right_q    <= 1'b1;
      ship_x_q       <= 5'(SHIP_START);
      bullet_x_q     <= '0;
      bullet_y_q     <= '0;
      flying_q       <= 1'b0;
      score_q        <= '0;
      ship_cnt_q     <= '0;
      bullet_cnt_q   <= '0;
      inv_cnt_q      <= '0;
      fire_pending_q <= 1'b0;
      fire_prev_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      inv_array_q    <= inv_array_d;
      inv_line_q     <= inv_line_d;
      dir_right_q    <= dir_right_d;
      ship_x_q       <= ship_x_d;
      bullet_x_q     <= bullet_x_d;
      bullet_y_q     <= bullet_y_d;
      flying_q       <= flying_d;
      score_q        <= score_d;
      ship_cnt_q     <= ship_cnt_d;
      bullet_cnt_q   <= bullet_cnt_d;
      inv_cnt_q      <= inv_cnt_d;
      fire_pending_q <= fire_pending_d;
      fire_prev_q    <= fire_prev_d;
    end
  end

  assign play_tick    = frame_tick && (state_q == ST_PLAY);
  assign start_game   = frame_tick && fire_pending_q && (state_q == ST_IDLE);
  assign restart_game = frame_tick && fire_pending_q &&
                        ((state_q == ST_WIN) || (state_q == ST_LOSE));

  assign ship_wrap   = (ship_cnt_q   == SHIP_CW'(SHIP_DIV - 1));
  assign bullet_wrap = (bullet_cnt_q == BULLET_CW'(BULLET_DIV - 1));
  assign inv_wrap    = (inv_cnt_q    == INV_CW'(INV_DIV - 1));

  // Hit test uses the register values at the start of the tick.
  assign hit = flying_q && ({1'b0, bullet_y_q} == inv_line_q) &&
               inv_array_q[bullet_x_q];

  // Next-state logic. End conditions look at the updated array/line so a
  // kill or an invader step on this tick is reflected immediately; an empty
  // board wins even if the block has reached the ship row.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (frame_tick && fire_pending_q) state_d = ST_PLAY;
      end
      ST_PLAY: begin
        if (frame_tick) begin
          if (inv_array_d == '0)                   state_d = ST_WIN;
          else if (inv_line_d == 5'(SHIP_ROW))     state_d = ST_LOSE;
        end
      end
      ST_WIN, ST_LOSE: begin
        if (frame_tick && fire_pending_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Object update. A fire request is a rising edge of btn_fire; any frame
  // tick consumes the pending request, whether or not it can be used. During
  // PLAY the steps run in a fixed order: hit, bullet move, fire, ship move,
  // invader move, with the invader move acting on the post-hit array.
  always_comb begin
    inv_array_d    = inv_array_q;
    inv_line_d     = inv_line_q;
    dir_right_d    = dir_right_q;
    ship_x_d       = ship_x_q;
    bullet_x_d     = bullet_x_q;
    bullet_y_d     = bullet_y_q;
    flying_d       = flying_q;
    score_d        = score_q;
    ship_cnt_d     = ship_cnt_q;
    bullet_cnt_d   = bullet_cnt_q;
    inv_cnt_d      = inv_cnt_q;
    post_hit_array = inv_array_q;
    fire_prev_d    = btn_fire;
    fire_pending_d = (fire_pending_q && !frame_tick) || (btn_fire && !fire_prev_q);

    if (restart_game) begin
      inv_array_d  = INIT_ARRAY;
      inv_line_d   = 5'(START_LINE);
      dir_right_d  = 1'b1;
      ship_x_d     = 5'(SHIP_START);
      bullet_x_d   = '0;
      bullet_y_d   = '0;
      flying_d     = 1'b0;
      ship_cnt_d   = '0;
      bullet_cnt_d = '0;
      inv_cnt_d    = '0;
    end else if (start_game) begin
      ship_cnt_d   = '0;
      bullet_cnt_d = '0;
      inv_cnt_d    = '0;
    end else if (play_tick) begin
      ship_cnt_d   = ship_wrap   ? '0 : ship_cnt_q   + 1'b1;
      bullet_cnt_d = bullet_wrap ? '0 : bullet_cnt_q + 1'b1;
      inv_cnt_d    = inv_wrap    ? '0 : inv_cnt_q    + 1'b1;

      if (hit) begin
        post_hit_array[bullet_x_q] = 1'b0;
        flying_d = 1'b0;
        score_d  = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
      end else if (flying_q && bullet_wrap) begin
        if (bullet_y_q == 4'd0) flying_d   = 1'b0;
        else                    bullet_y_d = bullet_y_q - 4'd1;
      end

      // Launch from the ship position before this tick's ship move.
      if (fire_pending_q && !flying_q) begin
        bullet_x_d = ship_x_q;
        bullet_y_d = 4'(SHIP_ROW - 1);
        flying_d   = 1'b1;
      end

      if (ship_wrap) begin
        if (btn_left && !btn_right && (ship_x_q != 5'd0))
          ship_x_d = ship_x_q - 5'd1;
        else if (btn_right && !btn_left && (ship_x_q != 5'(COLS - 1)))
          ship_x_d = ship_x_q + 5'd1;
      end

      inv_array_d = post_hit_array;
      if (inv_wrap) begin
        if (dir_right_q) begin
          if (post_hit_array[COLS-1]) begin
            inv_line_d  = inv_line_q + 5'd1;
            dir_right_d = 1'b0;
          end else begin
            inv_array_d = post_hit_array << 1;
          end
        end else begin
          if (post_hit_array[0]) begin
            inv_line_d  = inv_line_q + 5'd1;
            dir_right_d = 1'b1;
          end else begin
            inv_array_d = post_hit_array >> 1;
          end
        end
      end
    end
  end

  // Outputs come straight from the registers.
  always_comb begin
    invaders_array = inv_array_q;
    invaders_line  = inv_line_q;
    ship_x         = ship_x_q;
    bullet_x       = bullet_x_q;
    bullet_y       = bullet_y_q;
    bullet_flying  = flying_q;
    game_state     = state_q;
    score          = score_q;
  end

endmodule
